// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, processed DIGIT bits per clock, LSB slice first.
// Optional SERIAL_SUB_OVF_EN adds a signed-overflow flag (ovf) updated with done.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = $clog2(N + 1);

    generate
        if (WIDTH < 1 || WIDTH > 64 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH must be 1..64 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             brw_r;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] slice_d_c;
    logic             slice_bout_c;
    logic [WIDTH-1:0] res_next_c;
    logic             last_c;
    logic             accept_c;
`ifdef SERIAL_SUB_OVF_EN
    logic             msb_bin_c;
`endif

    assign last_c     = (cnt == CW'(N - 1));
    assign accept_c   = start && (state != RUN);
    assign res_next_c = (res_r >> DIGIT) | (WIDTH'(slice_d_c) << (WIDTH - DIGIT));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_c) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // One slice: borrow ripples combinationally through DIGIT full subtractors
    always_comb begin
        logic br;
        logic x;
        logic y;
        br        = brw_r;
        slice_d_c = '0;
`ifdef SERIAL_SUB_OVF_EN
        msb_bin_c = 1'b0;
`endif
        for (int i = 0; i < int'(DIGIT); i++) begin
            x = a_r[i];
            y = b_r[i];
`ifdef SERIAL_SUB_OVF_EN
            if (i == int'(DIGIT) - 1) msb_bin_c = br;
`endif
            slice_d_c[i] = x ^ y ^ br;
            br           = (~x & y) | (~x & br) | (y & br);
        end
        slice_bout_c = br;
    end

    // Operand shift registers, inter-slice borrow, counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            brw_r <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept_c) begin
            a_r   <= a;
            b_r   <= b;
            brw_r <= bin;
            res_r <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_r   <= a_r >> DIGIT;
            b_r   <= b_r >> DIGIT;
            brw_r <= slice_bout_c;
            res_r <= res_next_c;
            cnt   <= cnt + CW'(1);
            if (last_c) begin
                diff <= res_next_c;
                bout <= slice_bout_c;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= msb_bin_c ^ slice_bout_c;
`endif
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 1 to 64.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, enforced by an elaboration-time check.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only when busy=0.
REQ-006 a  input  WIDTH  minuend; captured on an accepted start.
REQ-007 b  input  WIDTH  subtrahend; captured on an accepted start.
REQ-008 bin  input  1  borrow-in; captured on an accepted start.
REQ-009 busy  output  1  high while a subtraction is in progress.
REQ-010 done  output  1  one-cycle pulse marking diff and bout as valid.
REQ-011 diff  output  WIDTH  result of a - b - bin, modulo 2^WIDTH.
REQ-012 bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).

Function
REQ-013 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE or DONE with start=1 at edge k: capture a, b, bin; clear the digit counter; go to RUN; busy=1 after edge k.
REQ-015 RUN: each edge processes one DIGIT-bit slice, LSB slice first.
REQ-016 Per-bit function: d = x^y^z; borrow = (~x&y) | (~x&z) | (y&z).
REQ-017 Within one slice, the borrow ripples combinationally; between slices it is carried in a register.
REQ-018 Let N = WIDTH/DIGIT. The last slice is processed at edge k+N; after that edge: state=DONE, busy=0, done=1.
REQ-019 DONE lasts exactly one cycle; it returns to IDLE unless start=1, in which case it goes to RUN with done=0 next cycle.
REQ-020 diff and bout SHALL hold their last result until the next done; during RUN they are not updated.
REQ-021 start while busy=1 is ignored; operand changes during RUN do not affect the result.
REQ-022 The digit counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap within one operation.
REQ-023 N=1 (DIGIT=WIDTH): busy is high for one cycle and done follows one edge after the start edge.

Reset
REQ-024 rst=1: state=IDLE; busy, done, diff, bout, counter, and internal borrow all = 0, immediately and regardless of clk.
REQ-025 Reset during RUN aborts the operation and produces no done.
REQ-026 The first start after rst deasserts is accepted normally.

Configuration
REQ-027 Macro SERIAL_SUB_OVF_EN defined: adds output port ovf (1 bit), reset value 0, updated only with done.
REQ-028 ovf=1 when a - b - bin, taken as WIDTH-bit two's-complement, falls outside the signed range (borrow into MSB XOR borrow out of MSB).
REQ-029 Macro undefined: no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-030 WIDTH=1, DIGIT=1, all 8 combinations of a, b, bin -> diff and bout match the full-subtractor truth table (for example 0-1-1 gives diff=0, bout=1); done arrives 1 cycle after start.
REQ-031 WIDTH=8, DIGIT=1, a=0x05, b=0x03, bin=0 -> busy high for 8 cycles, then done, diff=0x02, bout=0; a=0x00, b=0x01 -> diff=0xFF, bout=1.
REQ-032 WIDTH=8, DIGIT=4, a=0x10, b=0x01, bin=1 -> done 2 cycles after start, diff=0x0E, bout=0.
REQ-033 SERIAL_SUB_OVF_EN defined, WIDTH=8, a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0x01 -> ovf=0.
REQ-034 Start during RUN with different operands -> ignored, first result unchanged; start held high in the done cycle -> second operation completes N cycles later.
REQ-035 rst pulsed at RUN cycle 3 of 8 -> no done; outputs 0 immediately; a new start then completes correctly.
